// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared types and constants for the score display scheduler
package display_pkg;

  typedef enum logic [1:0] {LOAD, CONVERT, SHOW} state_t;

  localparam logic [1:0] SRC_SCORE   = 2'd0;
  localparam logic [1:0] SRC_HISCORE = 2'd1;
  localparam logic [1:0] SRC_TIMER   = 2'd2;
  localparam logic [7:0] BLANK_DIGIT = 8'h0F;

  function automatic logic [1:0] next_src(input logic [1:0] s);
    case (s)
      SRC_SCORE:   next_src = SRC_HISCORE;
      SRC_HISCORE: next_src = SRC_TIMER;
      default:     next_src = SRC_SCORE;
    endcase
  endfunction

endpackage

// File: rtl/display_scheduler_if.sv
// rtl/display_scheduler_if.sv - game values in, digit codes out
interface display_scheduler_if;

  logic [7:0] score;
  logic [7:0] hiscore;
  logic [7:0] timer;
  logic       score_evt;
  logic       rotate_en;
  logic [7:0] case4;
  logic [7:0] case5;
  logic [1:0] src;
  logic       valid;

  modport master (
    output score, hiscore, timer, score_evt, rotate_en,
    input  case4, case5, src, valid
  );

  modport slave (
    input  score, hiscore, timer, score_evt, rotate_en,
    output case4, case5, src, valid
  );

endinterface

// File: rtl/bin2bcd_iter.sv
// rtl/bin2bcd_iter.sv - iterative subtract-by-10 converter for values 0..99
module bin2bcd_iter (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       start,
  input  logic       abort,
  input  logic [6:0] value,
  output logic       done,
  output logic [3:0] tens,
  output logic [6:0] units
);

  logic [6:0] rem;
  logic [3:0] tens_q;
  logic       busy;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      rem    <= '0;
      tens_q <= '0;
      busy   <= 1'b0;
    end else if (abort) begin
      busy <= 1'b0;
    end else if (start) begin
      rem    <= value;
      tens_q <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      if (rem >= 7'd10) begin
        rem    <= rem - 7'd10;
        tens_q <= tens_q + 4'd1;
      end else begin
        busy <= 1'b0;
      end
    end
  end

  // done is the cycle in which rem holds the final units digit
  assign done  = busy && (rem < 7'd10);
  assign tens  = tens_q;
  assign units = rem;

endmodule

// File: rtl/display_scheduler.sv
// rtl/display_scheduler.sv - picks score/hiscore/timer, converts to two digits, holds them on display
module display_scheduler
  import display_pkg::*;
#(
  parameter int DWELL_CYCLES = 50_000_000
) (
  input  logic                Clock,
  input  logic                Resetn,
  display_scheduler_if.slave  bus
);

  localparam int              CW   = $clog2(DWELL_CYCLES);
  localparam logic [CW-1:0]   TERM = CW'(DWELL_CYCLES - 1);

  state_t        state, state_nxt;
  logic [1:0]    sel, sel_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [7:0]    v;
  logic [7:0]    cur;
  logic [7:0]    case4_q, case5_q;
  logic [1:0]    src_q;
  logic          valid_q;

  logic          start, abort, latch_v, commit_blank, commit_conv;
  logic          conv_done;
  logic [3:0]    conv_tens;
  logic [6:0]    conv_units;

  always_comb begin
    case (sel)
      SRC_HISCORE: cur = bus.hiscore;
      SRC_TIMER:   cur = bus.timer;
      default:     cur = bus.score;
    endcase
  end

  bin2bcd_iter u_conv (
    .Clock  (Clock),
    .Resetn (Resetn),
    .start  (start),
    .abort  (abort),
    .value  (cur[6:0]),
    .done   (conv_done),
    .tens   (conv_tens),
    .units  (conv_units)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= LOAD;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    sel_nxt      = sel;
    cnt_nxt      = cnt;
    start        = 1'b0;
    abort        = 1'b0;
    latch_v      = 1'b0;
    commit_blank = 1'b0;
    commit_conv  = 1'b0;
    case (state)
      LOAD: begin
        if (bus.score_evt) begin
          sel_nxt = SRC_SCORE;
          cnt_nxt = '0;
        end else begin
          latch_v = 1'b1;
          if (cur > 8'd99) begin
            commit_blank = 1'b1;
            state_nxt    = SHOW;
          end else begin
            start     = 1'b1;
            state_nxt = CONVERT;
          end
        end
      end
      CONVERT: begin
        if (bus.score_evt) begin
          abort     = 1'b1;
          sel_nxt   = SRC_SCORE;
          cnt_nxt   = '0;
          state_nxt = LOAD;
        end else if (conv_done) begin
          commit_conv = 1'b1;
          state_nxt   = SHOW;
        end
      end
      SHOW: begin
        if (bus.score_evt) begin
          sel_nxt   = SRC_SCORE;
          cnt_nxt   = '0;
          state_nxt = LOAD;
        end else if (cnt == TERM) begin
          cnt_nxt   = '0;
          sel_nxt   = bus.rotate_en ? next_src(sel) : SRC_SCORE;
          state_nxt = LOAD;
        end else begin
          // a value change reloads the same source without restarting its dwell
          cnt_nxt = cnt + 1'b1;
          if (cur != v) state_nxt = LOAD;
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      sel     <= SRC_SCORE;
      cnt     <= '0;
      v       <= '0;
      case4_q <= '0;
      case5_q <= '0;
      src_q   <= SRC_SCORE;
      valid_q <= 1'b0;
    end else begin
      sel <= sel_nxt;
      cnt <= cnt_nxt;
      if (latch_v) v <= cur;
      if (commit_blank) begin
        case4_q <= BLANK_DIGIT;
        case5_q <= BLANK_DIGIT;
        src_q   <= sel;
        valid_q <= 1'b1;
      end else if (commit_conv) begin
        case4_q <= {1'b0, conv_units};
        case5_q <= {4'b0000, conv_tens};
        src_q   <= sel;
        valid_q <= 1'b1;
      end
    end
  end

  assign bus.case4 = case4_q;
  assign bus.case5 = case5_q;
  assign bus.src   = src_q;
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_display_scheduler.sv
// tb/tb_display_scheduler.sv - randomized bench with a latency/arithmetic reference model
module tb_display_scheduler;

  localparam int D = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  display_scheduler_if bus();

  display_scheduler #(.DWELL_CYCLES(D)) dut (
    .Clock  (clk),
    .Resetn (rst_n),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference: 0 loading, 1 converting (m_left edges before commit), 2 showing
  int m_phase, m_left, m_v, m_sel, m_dwell;
  int e_c4, e_c5, e_src, e_valid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input int s);
    if (s == 0) return int'(bus.score);
    if (s == 1) return int'(bus.hiscore);
    return int'(bus.timer);
  endfunction

  task automatic model_reset();
    m_phase = 0; m_left = 0; m_v = 0; m_sel = 0; m_dwell = 0;
    e_c4 = 0; e_c5 = 0; e_src = 0; e_valid = 0;
  endtask

  task automatic model_edge();
    int cur;
    logic evt;
    evt = bus.score_evt;
    cur = pick(m_sel);
    case (m_phase)
      0: begin
        if (evt) begin
          m_sel = 0; m_dwell = 0;
        end else begin
          m_v = cur;
          if (cur > 99) begin
            e_c4 = 15; e_c5 = 15; e_src = m_sel; e_valid = 1; m_phase = 2;
          end else begin
            m_left = cur / 10; m_phase = 1;
          end
        end
      end
      1: begin
        if (evt) begin
          m_sel = 0; m_dwell = 0; m_phase = 0;
        end else if (m_left == 0) begin
          e_c4 = m_v % 10; e_c5 = m_v / 10; e_src = m_sel; e_valid = 1; m_phase = 2;
        end else begin
          m_left--;
        end
      end
      default: begin
        if (evt) begin
          m_sel = 0; m_dwell = 0; m_phase = 0;
        end else if (m_dwell == D - 1) begin
          m_dwell = 0;
          m_sel = bus.rotate_en ? (m_sel + 1) % 3 : 0;
          m_phase = 0;
        end else begin
          m_dwell++;
          if (cur != m_v) m_phase = 0;
        end
      end
    endcase
  endtask

  task automatic check_outputs(input string pfx);
    check({pfx, ".case4"}, 32'(bus.case4), e_c4);
    check({pfx, ".case5"}, 32'(bus.case5), e_c5);
    check({pfx, ".src"},   32'(bus.src),   e_src);
    check({pfx, ".valid"}, 32'(bus.valid), e_valid);
  endtask

  task automatic cyc(input string pfx);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(pfx);
    @(negedge clk);
  endtask

  task automatic run(input string pfx, input int n);
    for (int i = 0; i < n; i++) cyc(pfx);
  endtask

  task automatic do_reset(input string pfx);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs(pfx);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit found;
    bus.score = 8'd0; bus.hiscore = 8'd0; bus.timer = 8'd0;
    bus.score_evt = 1'b0; bus.rotate_en = 1'b0;
    model_reset();
    #12;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    run("first_commit", 4);

    bus.score = 8'd47;
    do_reset("reset47");
    run("score47", 10);

    bus.score = 8'd12; bus.hiscore = 8'd99; bus.timer = 8'd200; bus.rotate_en = 1'b1;
    run("rotate", 90);

    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (m_phase == 1 && m_sel == 1 && m_left >= 3 && m_left <= 6) found = 1'b1;
      else cyc("seek_hi");
    end
    check("evt_window_found", 32'(found), 32'd1);
    bus.score_evt = 1'b1;
    cyc("evt_abort");
    bus.score_evt = 1'b0;
    run("after_evt", 12);

    bus.rotate_en = 1'b0; bus.score = 8'd5;
    run("score5", 25);
    bus.score = 8'd63;
    run("score63", 30);

    bus.score = 8'd99;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_phase == 1 && m_left >= 2) found = 1'b1;
      else cyc("seek_conv");
    end
    check("conv_window_found", 32'(found), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run("post_reset", 15);

    for (int i = 0; i < 3000; i++) begin
      bus.score_evt = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 39) == 0) bus.rotate_en = ~bus.rotate_en;
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 2))
          0:       bus.score   = 8'($urandom_range(0, 120));
          1:       bus.hiscore = 8'($urandom_range(0, 140));
          default: bus.timer   = 8'($urandom_range(0, 255));
        endcase
      end
      cyc("random");
    end
    bus.score_evt = 1'b0;
    run("drain", 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
